regbank_dump_reader: RTL and testbench
======================================

// Module: regbank_dump_reader
// PURPOSE
//  Read-side sequencer for the 32x32 register bank. It sweeps an address range over one bank read port
//  and streams each {address, data} pair out over a valid/ready interface (debug dump, test scan-out).
//  Sits beside the CPU datapath and borrows one read-port address mux while busy; issues no writes.
// PARAMETERS
//  N    32  data width of one register / one output beat
//  BR   5   register address width (2**BR registers)
// PORTS
//  clk         in   1    rising-edge clock
//  rst         in   1    synchronous reset, active-high
//  start       in   1    request a dump; sampled only in IDLE
//  first_addr  in   BR   first register of the range; latched on accepted start
//  last_addr   in   BR   last register of the range, inclusive; latched on accepted start
//  busy        out  1    high from the cycle after accepted start until done
//  done        out  1    one-cycle pulse: dump finished
//  rd_addr     out  BR   drives the bank read-port address
//  rd_data     in   N    bank read data; combinational from rd_addr in the same cycle
//  out_valid   out  1    output beat valid
//  out_ready   in   1    consumer accepts the beat when out_valid && out_ready
//  out_addr    out  BR   register index of the current beat
//  out_data    out  N    register contents of the current beat
//  out_last    out  1    high on the final beat of the range
// BEHAVIOUR
//  Reset (rst=1 at an edge): state=IDLE; busy=0, done=0, out_valid=0, out_last=0, rd_addr=0,
//   out_addr=0, out_data=0.
//  Reset wins over every other event. Reset mid-dump aborts the dump: no done pulse, and the
//   pending beat is discarded.
//  FSM states: IDLE, SCAN, FLUSH.
//   IDLE->SCAN: start=1 && first_addr<=last_addr. Latch the range; ptr<=first_addr.
//   IDLE->IDLE: start=1 && first_addr>last_addr. No beats; done=1 for the next cycle only.
//   SCAN: rd_addr=ptr. Output stage loads when load = !out_valid || out_ready.
//    On load: out_data<=rd_data, out_addr<=ptr, out_valid<=1, out_last<=(ptr==last).
//    If ptr==last, go to FLUSH; otherwise ptr<=ptr+1.
//   FLUSH: hold the final beat until out_valid && out_ready. Then out_valid<=0, done<=1 for
//    one cycle, state<=IDLE.
//  Throughput: 1 beat/cycle while out_ready=1. First beat has out_valid=1 one cycle after the
//   start edge (latency 1).
//  Backpressure: while out_valid && !out_ready, out_* and ptr are held stable; no beat is dropped or duplicated.
//  start while busy: ignored. start is only sampled in IDLE, including the cycle done is high.
//  In IDLE, rd_addr=0 so the port is left at a harmless address.
//  Address 0 is dumped like any other index; the bank returns 0 for it.
//  Full range 0..2**BR-1: ptr must not wrap. Termination compares ptr==last, never an overflow flag.
//  Concurrent bank write to the address being captured: the pre-write value is captured, because
//   the read is combinational and the write lands at the edge.
//  Arithmetic: ptr is BR bits, unsigned; all range comparisons are unsigned.
// STRUCTURE
//  Shared package: state encoding (IDLE/SCAN/FLUSH localparams) and the default N=32, BR=5.
//  These are shared with the bank and with the debug controller that muxes rd_addr.
//  Single module, no sub-module. The one-entry output register stays inline.
//  Arbitration of rd_addr against the CPU is the instantiating level's job, qualified by busy.
// TESTING
//  1. Full dump: bank preloaded Rk=k*0x01010101, start with 0..31, out_ready=1
//     -> 32 beats on consecutive cycles, addr 0..31, data 0 then k*0x01010101;
//        out_last only on addr 31; done 1 cycle after the last beat.
//  2. Backpressure: range 4..7, out_ready toggled 1,0,0,1,0,1...
//     -> exactly 4 beats, addr 4,5,6,7 in order, out_* stable during stalls.
//  3. Empty/single range: first=9,last=3 -> no out_valid, done pulse next cycle;
//     first=last=5 -> one beat addr 5, out_last=1.
//  4. Reset mid-dump: rst=1 after the 3rd beat of 0..31
//     -> next edge out_valid=0, busy=0, no done; a new start 0..1 yields 2 correct beats.
//  5. start held high during a dump and a write to R6 in the capture cycle of R6
//     -> the second start is ignored; the old R6 value is dumped; a re-dump shows the new value.

Source files
------------

// File: rtl/regbank_dump_reader_pkg.sv
// Shared constants for the register bank and its dump sequencer: default geometry
// and the dump FSM state encoding used by the bank, the reader and the debug controller.
package regbank_dump_reader_pkg;

    localparam int DEF_N  = 32;
    localparam int DEF_BR = 5;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SCAN  = ST_SCAN,
        FLUSH = ST_FLUSH
    } state_t;

endpackage

// File: rtl/regbank_dump_reader.sv
// Sweeps an inclusive register range over one bank read port and streams
// {address, data} beats out through a one-entry valid/ready output register.
module regbank_dump_reader
    import regbank_dump_reader_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int BR = DEF_BR
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [BR-1:0] first_addr,
    input  logic [BR-1:0] last_addr,
    output logic          busy,
    output logic          done,
    output logic [BR-1:0] rd_addr,
    input  logic [N-1:0]  rd_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [BR-1:0] out_addr,
    output logic [N-1:0]  out_data,
    output logic          out_last,
    output state_t        dbg_state
);

    // Output handshake: a beat transfers on any rising edge where out_valid && out_ready.
    // While out_valid is high and out_ready low, out_addr/out_data/out_last do not change.

    state_t        state, state_n;
    logic [BR-1:0] ptr, ptr_n;
    logic [BR-1:0] last_q, last_n;
    logic          out_valid_n, out_last_n, done_n, load;
    logic [BR-1:0] out_addr_n;
    logic [N-1:0]  out_data_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            last_q    <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            last_q    <= last_n;
            out_valid <= out_valid_n;
            out_last  <= out_last_n;
            out_addr  <= out_addr_n;
            out_data  <= out_data_n;
            done      <= done_n;
        end
    end

    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        last_n      = last_q;
        out_valid_n = out_valid;
        out_last_n  = out_last;
        out_addr_n  = out_addr;
        out_data_n  = out_data;
        done_n      = 1'b0;
        rd_addr     = '0;
        load        = !out_valid || out_ready;

        case (state)
            IDLE: begin
                if (start) begin
                    if (first_addr <= last_addr) begin
                        state_n = SCAN;
                        ptr_n   = first_addr;
                        last_n  = last_addr;
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end
            SCAN: begin
                rd_addr = ptr;
                if (load) begin
                    out_data_n  = rd_data;
                    out_addr_n  = ptr;
                    out_valid_n = 1'b1;
                    out_last_n  = (ptr == last_q);
                    // Stop on equality so a range ending at the top index never wraps ptr.
                    if (ptr == last_q) begin
                        state_n = FLUSH;
                    end else begin
                        ptr_n = ptr + 1'b1;
                    end
                end
            end
            FLUSH: begin
                if (out_valid && out_ready) begin
                    out_valid_n = 1'b0;
                    out_last_n  = 1'b0;
                    done_n      = 1'b1;
                    state_n     = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_regbank_dump_reader.sv
// Bench for regbank_dump_reader: bank model with combinational read, directed dumps,
// and a scoreboard fed from the stimulus and drained by an output monitor.
module tb_regbank_dump_reader;
    import regbank_dump_reader_pkg::*;

    localparam int N  = DEF_N;
    localparam int BR = DEF_BR;
    localparam int W  = BR + N + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [BR-1:0] first_addr, last_addr;
    logic          busy, done;
    logic [BR-1:0] rd_addr;
    logic [N-1:0]  rd_data;
    logic          out_valid, out_ready, out_last;
    logic [BR-1:0] out_addr;
    logic [N-1:0]  out_data;
    state_t        dbg_state;

    logic          wr_en;
    logic [BR-1:0] wr_addr;
    logic [N-1:0]  wr_data;
    logic [N-1:0]  bank [32];

    logic [W-1:0]  exp_q[$];
    int            total = 0;
    int            bad = 0;
    int            beats_seen = 0;
    int            done_cnt = 0;
    logic          prev_stall = 1'b0;
    logic [W-1:0]  held;
    bit            pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    regbank_dump_reader #(.N(N), .BR(BR)) dut (
        .clk(clk), .rst(rst), .start(start), .first_addr(first_addr), .last_addr(last_addr),
        .busy(busy), .done(done), .rd_addr(rd_addr), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_data(out_data), .out_last(out_last), .dbg_state(dbg_state)
    );

    // clock / reset block
    always #5 clk = ~clk;

    // bank model: R0 reads 0, writes land at the edge, reset preloads Rk = k*0x01010101
    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 32; k++) bank[k] <= k * 32'h01010101;
        end else if (wr_en && wr_addr != '0) begin
            bank[wr_addr] <= wr_data;
        end
    end
    assign rd_data = bank[rd_addr];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int a, input logic [N-1:0] d, input bit l);
        exp_q.push_back({a[BR-1:0], d, l});
    endtask

    // monitor: pops on every accepted beat, checks hold during stalls, counts done pulses
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_hold", {out_addr, out_data, out_last}, held);
            end
            if (out_valid && out_ready) begin
                beats_seen++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got %0h expected none", {out_addr, out_data, out_last});
                end else begin
                    chk("beat", {out_addr, out_data, out_last}, exp_q.pop_front());
                end
            end
            prev_stall = out_valid && !out_ready;
            held = {out_addr, out_data, out_last};
            if (done) done_cnt++;
        end
    end

    // driver tasks
    task automatic start_dump(input int f, input int l);
        first_addr = f[BR-1:0];
        last_addr  = l[BR-1:0];
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_until_done(input bit toggle, input int c0, output int cyc);
        cyc = c0;
        while (cyc < 200) begin
            out_ready = toggle ? pat[cyc % 6] : 1'b1;
            @(posedge clk); #1;
            cyc++;
            if (done) break;
        end
        out_ready = 1'b1;
        chk("done_seen", done, 1);
    endtask

    initial begin
        int cyc;
        int base;
        bit wrote;
        rst = 1'b1; start = 1'b0; first_addr = '0; last_addr = '0;
        out_ready = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_last", out_last, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_out_addr", out_addr, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_state", dbg_state, IDLE);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: full dump 0..31 at full rate
        for (int k = 0; k < 32; k++) push_exp(k, k * 32'h01010101, k == 31);
        start_dump(0, 31);
        chk("t1_busy", busy, 1);
        chk("t1_valid_early", out_valid, 0);
        @(posedge clk); #1;
        chk("t1_first_valid", out_valid, 1);
        chk("t1_first_addr", out_addr, 0);
        run_until_done(1'b0, 1, cyc);
        chk("t1_cycles", cyc, 33);
        chk("t1_idle_rd_addr", rd_addr, 0);
        @(posedge clk); #1;
        chk("t1_done_pulse", done, 0);
        chk("t1_busy_after", busy, 0);
        chk("t1_done_cnt", done_cnt, 1);

        // 2: backpressure over 4..7
        push_exp(4, 32'h04040404, 0);
        push_exp(5, 32'h05050505, 0);
        push_exp(6, 32'h06060606, 0);
        push_exp(7, 32'h07070707, 1);
        start_dump(4, 7);
        run_until_done(1'b1, 0, cyc);
        @(posedge clk); #1;
        chk("t2_done_cnt", done_cnt, 2);
        chk("t2_queue", exp_q.size(), 0);

        // 3: empty range then single register
        start_dump(9, 3);
        chk("t3_empty_done", done, 1);
        chk("t3_empty_busy", busy, 0);
        @(posedge clk); #1;
        chk("t3_empty_done_off", done, 0);
        chk("t3_empty_valid", out_valid, 0);
        chk("t3_empty_done_cnt", done_cnt, 3);
        push_exp(5, 32'h05050505, 1);
        start_dump(5, 5);
        run_until_done(1'b0, 0, cyc);
        chk("t3_single_cycles", cyc, 2);
        @(posedge clk); #1;
        chk("t3_single_done_cnt", done_cnt, 4);

        // 4: reset after the third beat of a full dump
        push_exp(0, 32'h00000000, 0);
        push_exp(1, 32'h01010101, 0);
        push_exp(2, 32'h02020202, 0);
        base = beats_seen;
        start_dump(0, 31);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            if (beats_seen >= base + 3) break;
        end
        #1;
        chk("t4_three_beats", beats_seen - base, 3);
        rst = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        chk("t4_valid", out_valid, 0);
        chk("t4_busy", busy, 0);
        chk("t4_done", done, 0);
        chk("t4_state", dbg_state, IDLE);
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("t4_no_done", done_cnt, 4);
        chk("t4_queue", exp_q.size(), 0);
        push_exp(0, 32'h00000000, 0);
        push_exp(1, 32'h01010101, 1);
        start_dump(0, 1);
        run_until_done(1'b0, 0, cyc);
        @(posedge clk); #1;
        chk("t4_redump_done_cnt", done_cnt, 5);

        // 5: start held through a dump, write to R6 in its capture cycle
        for (int k = 0; k < 8; k++) push_exp(k, k * 32'h01010101, k == 7);
        first_addr = 5'd0;
        last_addr  = 5'd7;
        start = 1'b1;
        @(posedge clk); #1;
        first_addr = 5'd20;
        last_addr  = 5'd21;
        wrote = 1'b0;
        cyc = 0;
        while (cyc < 100) begin
            if (rd_addr == 5'd6 && !wrote) begin
                wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'hdeadbeef; wrote = 1'b1;
            end else begin
                wr_en = 1'b0;
                if (wrote) start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
            if (done) break;
        end
        wr_en = 1'b0;
        start = 1'b0;
        chk("t5_done_seen", done, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("t5_done_cnt", done_cnt, 6);
        chk("t5_idle_valid", out_valid, 0);
        chk("t5_idle_busy", busy, 0);
        push_exp(6, 32'hdeadbeef, 1);
        start_dump(6, 6);
        run_until_done(1'b0, 0, cyc);
        @(posedge clk); #1;
        chk("t5_redump_done_cnt", done_cnt, 7);
        chk("final_queue", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
